// File: rtl/calc_pkg.sv
// Shared constants for the keypad calculator sequencer:
// key codes, operator nibbles, FSM states and flag positions.
package calc_pkg;

    localparam logic [4:0] DIGIT_MAX = 5'd15;
    localparam logic [4:0] K_ADD     = 5'd16;
    localparam logic [4:0] K_SUB     = 5'd17;
    localparam logic [4:0] K_MUL     = 5'd18;
    localparam logic [4:0] K_AND     = 5'd19;
    localparam logic [4:0] K_OR      = 5'd20;
    localparam logic [4:0] K_EQ      = 5'd21;
    localparam logic [4:0] K_CE      = 5'd22;
    localparam logic [4:0] K_CLR     = 5'd23;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_OP  = 3'd1,
        S_B   = 3'd2,
        S_MUL = 3'd3,
        S_RES = 3'd4
    } state_t;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    // Operator keys 16..20 map onto op nibbles 1..5.
    function automatic logic [3:0] key2op(input logic [4:0] code);
        return code[3:0] + 4'd1;
    endfunction

endpackage

// File: rtl/mul_seq16.sv
// 16x16 unsigned shift-add multiplier, one partial product per cycle.
// done and p are valid in the cycle before the 16th iteration edge.
module mul_seq16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        done,
    output logic [31:0] p
);

    logic [31:0] r_acc;
    logic [31:0] r_mc;
    logic [15:0] r_mp;
    logic [4:0]  r_cnt;
    logic        r_run;
    logic [31:0] w_acc;

    assign w_acc = r_acc + (r_mp[0] ? r_mc : 32'h0);
    assign done  = r_run & (r_cnt == 5'd15);
    assign p     = w_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_mc  <= '0;
            r_mp  <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (abort) begin
            r_run <= 1'b0;
        end else if (start) begin
            r_acc <= '0;
            r_mc  <= {16'h0, a};
            r_mp  <= b;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_acc <= w_acc;
            r_mc  <= r_mc << 1;
            r_mp  <= r_mp >> 1;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd15)
                r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: operand entry, operator latch, ALU and
// display/flag output registers driven from the selected keypad cell.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic        CLK82MHZ,
    input  logic        CPU_RESETN,
    input  logic [2:0]  x,
    input  logic [1:0]  y,
    input  logic        enter,
    output logic [39:0] mostrar,
    output logic [3:0]  flags,
    output logic        busy
);

    localparam logic [2:0] MAXD = 3'(MAX_DIGITS);

    state_t      r_state, w_nstate;
    logic [15:0] r_a, r_b, w_na, w_nb;
    logic [3:0]  r_op, w_nop;
    logic [2:0]  r_cnt, w_ncnt;
    logic [31:0] r_r, w_nr;
    logic        r_c, w_nc;
    logic        r_enter_d;
    logic [39:0] r_mostrar, w_nmostrar;
    logic [3:0]  r_flags, w_nflags;
    logic        r_busy;

    logic [4:0]  w_code;
    logic [3:0]  w_d;
    logic        w_key;
    logic        w_is_dig, w_is_op, w_is_eq, w_is_ce, w_is_clr;
    logic [16:0] w_sum;
    logic [31:0] w_alu_r;
    logic        w_alu_c;
    logic        w_start, w_abort, w_done;
    logic [31:0] w_p;

    assign w_code = ({3'b0, y} * 5'd6) + {2'b0, x};
    assign w_d    = w_code[3:0];
    assign w_key  = enter & ~r_enter_d & (x <= 3'd5);

    always_comb begin
        w_is_dig = 1'b0;
        w_is_op  = 1'b0;
        w_is_eq  = 1'b0;
        w_is_ce  = 1'b0;
        w_is_clr = 1'b0;
        if (w_key) begin
            unique case (1'b1)
                (w_code <= DIGIT_MAX):                 w_is_dig = 1'b1;
                (w_code >= K_ADD && w_code <= K_OR):   w_is_op  = 1'b1;
                (w_code == K_EQ):                      w_is_eq  = 1'b1;
                (w_code == K_CE):                      w_is_ce  = 1'b1;
                (w_code == K_CLR):                     w_is_clr = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sum   = {1'b0, r_a} + {1'b0, r_b};
        w_alu_r = '0;
        w_alu_c = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_alu_r = {16'h0, w_sum[15:0]};
                w_alu_c = w_sum[16];
            end
            OP_SUB: begin
                w_alu_r = {16'h0, r_a - r_b};
                w_alu_c = (r_a < r_b);
            end
            OP_AND:  w_alu_r = {16'h0, r_a & r_b};
            OP_OR:   w_alu_r = {16'h0, r_a | r_b};
            default: w_alu_r = '0;
        endcase
    end

    always_comb begin
        w_nstate = r_state;
        w_na     = r_a;
        w_nb     = r_b;
        w_nop    = r_op;
        w_ncnt   = r_cnt;
        w_nr     = r_r;
        w_nc     = r_c;
        w_start  = 1'b0;
        w_abort  = 1'b0;
        // CE on a shown result behaves as a full clear.
        if (w_is_clr || (w_is_ce && r_state == S_RES)) begin
            w_nstate = S_A;
            w_na     = '0;
            w_nb     = '0;
            w_nop    = OP_NONE;
            w_ncnt   = '0;
            w_nr     = '0;
            w_nc     = 1'b0;
            w_abort  = (r_state == S_MUL);
        end else begin
            case (r_state)
                S_A: begin
                    if (w_is_dig && r_cnt < MAXD) begin
                        w_na   = {r_a[11:0], w_d};
                        w_ncnt = r_cnt + 3'd1;
                    end else if (w_is_op) begin
                        w_nop    = key2op(w_code);
                        w_nstate = S_OP;
                    end else if (w_is_ce) begin
                        w_na   = '0;
                        w_ncnt = '0;
                    end
                end
                S_OP: begin
                    if (w_is_dig) begin
                        w_nb     = {12'h0, w_d};
                        w_ncnt   = 3'd1;
                        w_nstate = S_B;
                    end else if (w_is_op) begin
                        w_nop = key2op(w_code);
                    end else if (w_is_ce) begin
                        w_nop    = OP_NONE;
                        w_ncnt   = '0;
                        w_nstate = S_A;
                    end
                end
                S_B: begin
                    if (w_is_dig && r_cnt < MAXD) begin
                        w_nb   = {r_b[11:0], w_d};
                        w_ncnt = r_cnt + 3'd1;
                    end else if (w_is_ce) begin
                        w_nb   = '0;
                        w_ncnt = '0;
                    end else if (w_is_eq && r_op == OP_MUL) begin
                        w_start  = 1'b1;
                        w_nstate = S_MUL;
                    end else if (w_is_eq) begin
                        w_nr     = w_alu_r;
                        w_nc     = w_alu_c;
                        w_nstate = S_RES;
                    end
                end
                S_MUL: begin
                    if (w_done) begin
                        w_nr     = w_p;
                        w_nc     = 1'b0;
                        w_nstate = S_RES;
                    end
                end
                S_RES: begin
                    if (w_is_dig) begin
                        w_na     = {12'h0, w_d};
                        w_nb     = '0;
                        w_nop    = OP_NONE;
                        w_ncnt   = 3'd1;
                        w_nstate = S_A;
                    end else if (w_is_op) begin
                        w_na     = r_r[15:0];
                        w_nb     = '0;
                        w_nop    = key2op(w_code);
                        w_ncnt   = '0;
                        w_nstate = S_OP;
                    end
                end
                default: w_nstate = S_A;
            endcase
        end
    end

    always_comb begin
        w_nflags = 4'b0000;
        if (w_nstate == S_RES) begin
            w_nflags[F_Z] = (w_nr == 32'h0);
            w_nflags[F_N] = (w_nop == OP_MUL) ? w_nr[31] : w_nr[15];
            w_nflags[F_C] = w_nc;
            w_nflags[F_V] = 1'b1;
        end
        w_nmostrar = (w_nstate == S_RES) ? {8'h00, w_nr}
                                          : {w_na, w_nop, w_nb, 4'h0};
    end

    always_ff @(posedge CLK82MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state   <= S_A;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= OP_NONE;
            r_cnt     <= '0;
            r_r       <= '0;
            r_c       <= 1'b0;
            r_enter_d <= 1'b0;
            r_mostrar <= '0;
            r_flags   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_a       <= w_na;
            r_b       <= w_nb;
            r_op      <= w_nop;
            r_cnt     <= w_ncnt;
            r_r       <= w_nr;
            r_c       <= w_nc;
            r_enter_d <= enter;
            r_mostrar <= w_nmostrar;
            r_flags   <= w_nflags;
            r_busy    <= (w_nstate == S_MUL);
        end
    end

    mul_seq16 u_mul (
        .clk   (CLK82MHZ),
        .rst_n (CPU_RESETN),
        .start (w_start),
        .abort (w_abort),
        .a     (r_a),
        .b     (r_b),
        .done  (w_done),
        .p     (w_p)
    );

    assign mostrar = r_mostrar;
    assign flags   = r_flags;
    assign busy    = r_busy;

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Key-driven sequencer for the 6x4 on-screen keypad calculator. It turns the selected cell (`x`, `y`) and `enter` into operand entry, operator selection and result computation. It drives the 40-bit `mostrar` nibble word that feeds the display converter and the 4-bit `flags` word that feeds the flag indicators. It sits between the PS/2 key decoder and the display pixel generators, replacing the combinational input handler.

## Interface
- `MAX_DIGITS`, default 4: hex digits accepted per operand; legal range 1..4.
- `CLK82MHZ`  in  1: pixel/system clock; all state on the rising edge.
- `CPU_RESETN`  in  1: asynchronous, active-low reset.
- `x`  in  3: selected column, 0..5; 6..7 are invalid.
- `y`  in  2: selected row, 0..3.
- `enter`  in  1: level, synchronous to `CLK82MHZ`; each rising edge is one key event.
- `mostrar`  out  40: display nibbles, registered.
- `flags`  out  4: {Z, N, C, VALID}, registered.
- `busy`  out  1: high while a multiply is in progress, registered.

## Operation
- **Key event:** `ev = enter & ~enter_d`. Code = `y*6 + x`.
  - Codes 0..15: hex digits 0..F.
  - 16 ADD, 17 SUB, 18 MUL, 19 AND, 20 OR, 21 EQ, 22 CE, 23 CLR.
  - An event with `x > 5` is ignored.
- **Registers:** A[15:0], B[15:0], op[3:0] (0 none, 1..5 = ADD..OR), digit count cnt, R[31:0], flag bits.
- **States:** S_A, S_OP, S_B, S_MUL, S_RES. Reset state is S_A with everything 0.
- **Digit entry:** `{reg[11:0], d}` when cnt < MAX_DIGITS, then cnt++. Extra digits are ignored.
- **S_A**
  - digit: shift into A.
  - ADD..OR: latch op, go to S_OP.
  - EQ: ignored.
  - CE: A=0, cnt=0.
- **S_OP**
  - digit: B=d, cnt=1, go to S_B.
  - ADD..OR: replace op.
  - CE: op=0, go to S_A with cnt=0; A is kept.
  - EQ: ignored.
- **S_B**
  - digit: shift into B.
  - ADD..OR: ignored.
  - CE: B=0, cnt=0.
  - EQ with op=MUL: go to S_MUL.
  - EQ with any other op: compute in the same edge, go to S_RES.
- **S_MUL:** 16-iteration shift-add multiply. Every event except CLR is dropped, not queued.
- **S_RES**
  - digit: A=d, B=0, op=0, cnt=1, go to S_A.
  - ADD..OR: A=R[15:0], latch op, B=0, go to S_OP (chaining).
  - EQ: ignored.
  - CE: same as CLR.
- **CLR:** honoured in every state, including S_MUL (aborts the multiply). Clears all registers and goes to S_A.
- **Arithmetic:**
  - ADD: R = {16'h0, A+B}; C = carry out of bit 15.
  - SUB: R = {16'h0, A-B}; C = borrow (A < B).
  - AND, OR: R = {16'h0, A op B}; C = 0.
  - MUL: R = A*B, 32-bit unsigned; C = 0.
  - Z = (R == 0).
  - N = R[15], or R[31] for MUL.
- **`mostrar`:**
  - In S_A, S_OP, S_B, S_MUL: `{A, op, B, 4'h0}`.
  - In S_RES: `{8'h00, R}`.
- **`flags`:** {Z, N, C, 1} in S_RES, otherwise 4'b0000.

## Timing
- Reset: `mostrar` = 0, `flags` = 0, `busy` = 0, `enter_d` = 0, state = S_A.
- An `enter` held high for any duration is one event. A new event needs `enter` to go low for at least 1 cycle.
- **Latency:** `enter` first sampled high at edge k updates the registers and outputs at edge k.
- **MUL:**
  - EQ at edge k sets `busy` at k.
  - Iterations run on edges k+1..k+16.
  - S_RES, `busy`=0, the result and the flags all appear at edge k+16.
- CLR at any edge during S_MUL: `busy`=0 and state S_A at that same edge.
- Reset asserted mid-multiply: all registers clear immediately, asynchronously.

## Structure
- **Package `calc_pkg`:**
  - Key-code constants (DIGIT_MAX=15, K_ADD..K_CLR).
  - Op nibble encodings.
  - State enum encoding (3 bits).
  - Flag bit positions.
- **Sub-module `mul_seq16`:** shift-add multiplier.
  - Inputs: `start`, `abort`, `a`, `b`.
  - Outputs: `done` (1-cycle pulse), `p[31:0]`.
  - Internal 5-bit iteration counter.
- Top level holds the FSM, entry registers, ALU and output registers.

## Test plan
1. **Reset:** assert `CPU_RESETN`=0 → `mostrar`=0, `flags`=0, `busy`=0; release, then EQ → no change.
2. **ADD:** keys 1 (x1,y0), 2 (x2,y0), ADD (x4,y2), 3 (x3,y0), EQ (x3,y3) → `mostrar`=40'h00_0000_0015, `flags`=4'b0001.
3. **ADD carry, SUB borrow:**
   - FFFF + 0001 → R=0, `flags`=4'b1011.
   - 0003 - 0005 → R=0000FFFE, `flags`=4'b0111.
4. **MUL:** 00FF * 0100 → `busy` high 16 cycles; at EQ+16 `mostrar`=40'h00_0000_FF00, `flags`=4'b0001. An ADD key pressed during `busy` is ignored.
5. **Abort:** CLR (x5,y3) on the 5th cycle of S_MUL → `busy`=0, `mostrar`=0 at that edge; a later multiply works normally.
6. **Entry limits and chaining:**
   - Digits 1,2,3,4,5 → A=1234.
   - `enter` held 100 cycles counts once.
   - After result 0015, ADD, 1, EQ → 0016.
